// File: rtl/rsa2048_pkg.sv
`default_nettype none
//============================================================================
// Module      : rsa2048_pkg
// Description : Shared constants, register offsets and state encoding for
//               the RSA2048 AHB-Lite register front end.
// Revision    : 1.0 - initial release
//============================================================================
package rsa2048_pkg;

    // Operand/result width and the number of 32-bit beats that make one up
    localparam int KEY_BITS = 2048;
    localparam int WORDS    = KEY_BITS / 32;

    // Word offsets, HADDR[4:2]
    localparam logic [2:0] OFS_CTRL   = 3'd0;
    localparam logic [2:0] OFS_STATUS = 3'd1;
    localparam logic [2:0] OFS_DATA   = 3'd4;

    // CTRL interrupt-enable bit
    localparam int IE_BIT = 1;

    // Only full-word transfers may modify registers
    localparam logic [2:0] SIZE_WORD = 3'b010;

    // Sequencer states; the enum names the encoding, the localparams are
    // what the state register is compared against
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        BUSY = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_LOAD = LOAD;
    localparam logic [1:0] ST_BUSY = BUSY;
    localparam logic [1:0] ST_DONE = DONE;

    // STATUS register image: bit1 = busy, bit0 = done
    function automatic logic [31:0] status_word(input logic busy, input logic done);
        return {30'd0, busy, done};
    endfunction

endpackage : rsa2048_pkg
`default_nettype wire

// File: rtl/rsa2048_ahb_slave_if.sv
`default_nettype none
//============================================================================
// Module      : ahb_slave_if
// Description : AHB-Lite address-phase capture. Turns the registered
//               address-phase info into data-phase write/read strobes, a
//               word offset and a full-word size flag.
// Revision    : 1.0 - initial release
//============================================================================
module ahb_slave_if
    import rsa2048_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_hsel,
    input  logic       i_htrans_valid,
    input  logic       i_hready,
    input  logic       i_hwrite,
    input  logic [2:0] i_haddr_ofs,
    input  logic [2:0] i_hsize,
    output logic       o_wr_en,
    output logic       o_rd_en,
    output logic [2:0] o_ofs,
    output logic       o_size_ok
);

    logic       r_valid;
    logic       r_write;
    logic       r_size_ok;
    logic [2:0] r_ofs;

    // Register the address phase; a stalled bus keeps the current data phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_write   <= 1'b0;
            r_size_ok <= 1'b0;
            r_ofs     <= 3'd0;
        end else if (i_hready) begin
            r_valid   <= i_hsel & i_htrans_valid;
            r_write   <= i_hwrite;
            r_size_ok <= (i_hsize == SIZE_WORD);
            r_ofs     <= i_haddr_ofs;
        end
    end

    // Writes commit on the edge that ends the data phase, so they need HREADY;
    // read data is driven for the whole data phase regardless
    assign o_wr_en   = r_valid & r_write & i_hready;
    assign o_rd_en   = r_valid & ~r_write;
    assign o_ofs     = r_ofs;
    assign o_size_ok = r_size_ok;

endmodule : ahb_slave_if
`default_nettype wire

// File: rtl/rsa2048_ahb_slave.sv
`default_nettype none
//============================================================================
// Module      : rsa2048_ahb_slave
// Description : Word-serial AHB-Lite register front end for the RSA2048
//               core: CTRL / STATUS / DATA window, operand load, start
//               pulse, result capture and drain, completion interrupt.
// Revision    : 1.0 - initial release
//============================================================================
module rsa2048_ahb_slave
    import rsa2048_pkg::*;
(
    input  logic                HCLK,
    input  logic                HRESET,
    input  logic                HSEL,
    input  logic [31:0]         HADDR,
    input  logic [1:0]          HTRANS,
    input  logic                HWRITE,
    input  logic [2:0]          HSIZE,
    input  logic [31:0]         HWDATA,
    input  logic                HREADY,
    output logic                HREADYOUT,
    output logic [1:0]          HRESP,
    output logic [31:0]         HRDATA,
    output logic                IRQ,
    output logic [KEY_BITS-1:0] rsa_x_o,
    output logic                rsa_start_o,
    input  logic                rsa_done_i,
    input  logic [KEY_BITS-1:0] rsa_result_i
);

    logic                w_wr_en;
    logic                w_rd_en;
    logic [2:0]          w_ofs;
    logic                w_size_ok;
    logic                w_ctrl_wr;
    logic                w_data_wr;
    logic                w_data_pop;
    logic                w_arm;
    logic                w_unused;
    logic [31:0]         w_rdata;

    logic [1:0]          r_state;
    logic [KEY_BITS-1:0] r_x_sr;
    logic [KEY_BITS-1:0] r_res_sr;
    logic [6:0]          r_wcnt;
    logic [6:0]          r_rcnt;
    logic                r_done;
    logic                r_ie;
    logic                r_start;

    // Address bits outside [4:2] and HTRANS[0] carry no meaning here
    assign w_unused = &{1'b0, HADDR[31:5], HADDR[1:0], HTRANS[0]};

    ahb_slave_if u_if (
        .clk            (HCLK),
        .rst            (HRESET),
        .i_hsel         (HSEL),
        .i_htrans_valid (HTRANS[1]),
        .i_hready       (HREADY),
        .i_hwrite       (HWRITE),
        .i_haddr_ofs    (HADDR[4:2]),
        .i_hsize        (HSIZE),
        .o_wr_en        (w_wr_en),
        .o_rd_en        (w_rd_en),
        .o_ofs          (w_ofs),
        .o_size_ok      (w_size_ok)
    );

    assign w_ctrl_wr  = w_wr_en & w_size_ok & (w_ofs == OFS_CTRL);
    assign w_data_wr  = w_wr_en & w_size_ok & (w_ofs == OFS_DATA);
    assign w_data_pop = w_rd_en & HREADY & (w_ofs == OFS_DATA);
    // The core owns the operand while busy, so CTRL cannot re-arm then
    assign w_arm      = w_ctrl_wr & (r_state != ST_BUSY);

    // Sequencer: arm, shift operand in, start, capture result, shift result out
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state  <= ST_IDLE;
            r_x_sr   <= '0;
            r_res_sr <= '0;
            r_wcnt   <= 7'd0;
            r_rcnt   <= 7'd0;
            r_done   <= 1'b0;
            r_ie     <= 1'b0;
            r_start  <= 1'b0;
        end else begin
            r_start <= 1'b0;
            if (w_arm) begin
                r_wcnt  <= 7'd0;
                r_rcnt  <= 7'd0;
                r_done  <= 1'b0;
                r_ie    <= HWDATA[IE_BIT];
                r_state <= ST_LOAD;
            end else begin
                case (r_state)
                    ST_LOAD: begin
                        if (w_data_wr) begin
                            // First word written ends up as the least significant word
                            r_x_sr <= {HWDATA, r_x_sr[KEY_BITS-1:32]};
                            r_wcnt <= r_wcnt + 7'd1;
                            if (r_wcnt == 7'(WORDS - 1)) begin
                                r_start <= 1'b1;
                                r_state <= ST_BUSY;
                            end
                        end
                    end
                    ST_BUSY: begin
                        if (rsa_done_i) begin
                            r_res_sr <= rsa_result_i;
                            r_done   <= 1'b1;
                            r_state  <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        if (w_data_pop && (r_rcnt < 7'(WORDS))) begin
                            r_res_sr <= {32'd0, r_res_sr[KEY_BITS-1:32]};
                            r_rcnt   <= r_rcnt + 7'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Read mux driven from the registered data-phase offset
    always_comb begin
        w_rdata = 32'd0;
        if (w_rd_en) begin
            case (w_ofs)
                OFS_CTRL:   w_rdata[IE_BIT] = r_ie;
                OFS_STATUS: w_rdata = status_word(r_state == ST_BUSY, r_done);
                OFS_DATA: begin
                    if ((r_state == ST_DONE) && (r_rcnt < 7'(WORDS)))
                        w_rdata = r_res_sr[31:0];
                end
                default: ;
            endcase
        end
    end

    assign HRDATA      = w_rdata;
    assign HREADYOUT   = 1'b1;
    assign HRESP       = 2'b00;
    assign IRQ         = r_done & r_ie;
    assign rsa_x_o     = r_x_sr;
    assign rsa_start_o = r_start;

endmodule : rsa2048_ahb_slave
`default_nettype wire

// File: tb/tb_rsa2048_ahb_slave.sv
`default_nettype none
//============================================================================
// Module      : tb_rsa2048_ahb_slave
// Description : Self-checking bench for rsa2048_ahb_slave: register-access
//               vector table plus load / busy / drain / re-arm / reset
//               sequences, with a queue of expected drain words.
// Revision    : 1.0 - initial release
//============================================================================
module tb_rsa2048_ahb_slave;
    import rsa2048_pkg::*;

    logic                HCLK = 1'b0;
    logic                HRESET;
    logic                HSEL;
    logic [31:0]         HADDR;
    logic [1:0]          HTRANS;
    logic                HWRITE;
    logic [2:0]          HSIZE;
    logic [31:0]         HWDATA;
    logic                HREADY;
    logic                HREADYOUT;
    logic [1:0]          HRESP;
    logic [31:0]         HRDATA;
    logic                IRQ;
    logic [KEY_BITS-1:0] rsa_x_o;
    logic                rsa_start_o;
    logic                rsa_done_i;
    logic [KEY_BITS-1:0] rsa_result_i;

    logic [KEY_BITS-1:0] exp_x;
    logic [31:0]         sb_q[$];
    int                  n_tests = 0;
    int                  n_fail  = 0;
    int                  start_cnt = 0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  size;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vt[11];

    always #5 HCLK = ~HCLK;

    rsa2048_ahb_slave dut (
        .HCLK         (HCLK),
        .HRESET       (HRESET),
        .HSEL         (HSEL),
        .HADDR        (HADDR),
        .HTRANS       (HTRANS),
        .HWRITE       (HWRITE),
        .HSIZE        (HSIZE),
        .HWDATA       (HWDATA),
        .HREADY       (HREADY),
        .HREADYOUT    (HREADYOUT),
        .HRESP        (HRESP),
        .HRDATA       (HRDATA),
        .IRQ          (IRQ),
        .rsa_x_o      (rsa_x_o),
        .rsa_start_o  (rsa_start_o),
        .rsa_done_i   (rsa_done_i),
        .rsa_result_i (rsa_result_i)
    );

    // Count start pulses seen by the core
    always @(negedge HCLK) if (rsa_start_o === 1'b1) start_cnt++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check_x(input string name);
        int bad = 0;
        for (int k = 0; k < WORDS; k++)
            if (rsa_x_o[32*k +: 32] !== exp_x[32*k +: 32]) bad++;
        check(name, bad, 0);
    endtask

    task automatic bus_idle();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        HADDR  = 32'd0;
        HSIZE  = 3'b010;
    endtask

    // One non-pipelined transfer; returns at mid data phase. A write commits
    // on the next rising edge.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] size, output logic [31:0] rdata);
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = wr; HADDR = addr; HSIZE = size;
        @(posedge HCLK); #1;
        bus_idle();
        HWDATA = wdata;
        @(negedge HCLK);
        rdata = HRDATA;
    endtask

    task automatic wr32(input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] d;
        xfer(1'b1, addr, wdata, 3'b010, d);
    endtask

    task automatic rd32(input logic [31:0] addr, output logic [31:0] rdata);
        xfer(1'b0, addr, 32'd0, 3'b010, rdata);
    endtask

    // Back-to-back reads; each data-phase word is compared with the queue head
    task automatic burst_read(input logic [31:0] addr, input int n);
        logic [31:0] e;
        for (int i = 0; i <= n; i++) begin
            @(posedge HCLK); #1;
            if (i < n) begin
                HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr; HSIZE = 3'b010;
            end else begin
                bus_idle();
            end
            @(negedge HCLK);
            if (i > 0) begin
                if (sb_q.size() == 0) begin
                    check("scoreboard_empty", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check($sformatf("drain[%0d]", i - 1), HRDATA, e);
                end
            end
        end
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] w;
        int          s0;

        HRESET = 1'b1;
        bus_idle();
        HWDATA = 32'd0;
        HREADY = 1'b1;
        rsa_done_i = 1'b0;
        rsa_result_i = '0;

        // Reset state
        repeat (3) @(posedge HCLK);
        #1;
        check("rst_hrdata", HRDATA, 32'd0);
        check("rst_irq", IRQ, 32'd0);
        check("rst_start", rsa_start_o, 32'd0);
        check("rst_hreadyout", HREADYOUT, 32'd1);
        check("rst_hresp", HRESP, 32'd0);
        exp_x = '0;
        check_x("rst_x");
        @(posedge HCLK); #1;
        HRESET = 1'b0;

        // Register-access vectors
        vt[0]  = '{1'b0, 32'h04, 32'h0,        3'b010, 32'h0, "rst_status"};
        vt[1]  = '{1'b0, 32'h10, 32'h0,        3'b010, 32'h0, "idle_data_read"};
        vt[2]  = '{1'b0, 32'h08, 32'h0,        3'b010, 32'h0, "ofs2_read"};
        vt[3]  = '{1'b1, 32'h00, 32'h2,        3'b010, 32'h0, "ctrl_wr_ie"};
        vt[4]  = '{1'b0, 32'h00, 32'h0,        3'b010, 32'h2, "ctrl_read_ie"};
        vt[5]  = '{1'b0, 32'h04, 32'h0,        3'b010, 32'h0, "load_status"};
        vt[6]  = '{1'b1, 32'h08, 32'hFFFFFFFF, 3'b010, 32'h0, "ofs2_write"};
        vt[7]  = '{1'b0, 32'h08, 32'h0,        3'b010, 32'h0, "ofs2_after_write"};
        vt[8]  = '{1'b0, 32'h1C, 32'h0,        3'b010, 32'h0, "ofs7_read"};
        vt[9]  = '{1'b1, 32'h00, 32'h0,        3'b000, 32'h0, "ctrl_bad_size_wr"};
        vt[10] = '{1'b0, 32'h00, 32'h0,        3'b000, 32'h2, "ctrl_bad_size_rd"};
        for (int i = 0; i < 11; i++) begin
            xfer(vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].size, d);
            if (!vt[i].wr) check(vt[i].name, d, vt[i].exp);
        end

        // Load 64 operand words
        wr32(32'h00, 32'hFFFFFFFF);
        s0 = start_cnt;
        for (int k = 0; k < WORDS; k++) exp_x[32*k +: 32] = 32'h1000_0000 + 32'(k);
        for (int k = 0; k < WORDS - 1; k++) wr32(32'h10, 32'h1000_0000 + 32'(k));
        // Last word pipelined with a STATUS read in its data phase
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h10; HSIZE = 3'b010;
        @(posedge HCLK); #1;
        HWDATA = 32'h1000_003F; HWRITE = 1'b0; HADDR = 32'h04;
        @(negedge HCLK);
        check("no_early_start", rsa_start_o, 32'd0);
        @(posedge HCLK); #1;
        bus_idle();
        @(negedge HCLK);
        check("status_after_last_wr", HRDATA, 32'h2);
        check("start_pulse", rsa_start_o, 32'd1);
        @(negedge HCLK);
        check("start_one_cycle", rsa_start_o, 32'd0);
        #1;
        check("start_count_load", start_cnt - s0, 32'd1);
        check_x("x_loaded");

        // Busy: polls, ignored DATA and CTRL writes
        rd32(32'h04, d);
        check("busy_status", d, 32'h2);
        wr32(32'h10, 32'hDEADBEEF);
        wr32(32'h00, 32'h0);
        @(posedge HCLK); #1;
        check_x("x_hold_busy");
        check("busy_irq", IRQ, 32'd0);

        // Core completes
        rsa_result_i = ~exp_x;
        rsa_done_i   = 1'b1;
        @(negedge HCLK);
        check("irq_before_done_edge", IRQ, 32'd0);
        @(posedge HCLK); #1;
        rsa_done_i   = 1'b0;
        rsa_result_i = '0;
        @(negedge HCLK);
        check("irq_after_done", IRQ, 32'd1);
        rd32(32'h04, d);
        check("done_status", d, 32'h1);

        // Drain back-to-back, then past the end
        for (int k = 0; k < WORDS; k++) begin
            w = 32'h1000_0000 + 32'(k);
            sb_q.push_back(~w);
        end
        sb_q.push_back(32'h0);
        burst_read(32'h10, WORDS + 1);
        rd32(32'h10, d);
        check("read_past_end", d, 32'h0);
        check("irq_held", IRQ, 32'd1);

        // Re-arm, abort a partial load, then a clean load with a bad-size write
        wr32(32'h00, 32'h0);
        @(posedge HCLK); #1;
        check("rearm_irq", IRQ, 32'd0);
        rd32(32'h04, d);
        check("rearm_status", d, 32'h0);
        for (int k = 0; k < 10; k++) wr32(32'h10, 32'h2000_0000 + 32'(k));
        wr32(32'h00, 32'h0);
        s0 = start_cnt;
        for (int k = 0; k < WORDS; k++) exp_x[32*k +: 32] = 32'h3000_0000 + 32'(k);
        for (int k = 0; k < WORDS; k++) begin
            if (k == 20) xfer(1'b1, 32'h10, 32'hBAD0BAD0, 3'b001, d);
            wr32(32'h10, 32'h3000_0000 + 32'(k));
        end
        @(posedge HCLK);
        @(negedge HCLK);
        check("rearm_start", rsa_start_o, 32'd1);
        #1;
        check("start_count_rearm", start_cnt - s0, 32'd1);
        check_x("x_rearm");

        // Reset while the start pulse is high, then a late done
        HRESET = 1'b1;
        #1;
        check("start_cancel", rsa_start_o, 32'd0);
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        rsa_result_i = {KEY_BITS{1'b1}};
        rsa_done_i   = 1'b1;
        repeat (2) @(posedge HCLK);
        #1;
        rsa_done_i   = 1'b0;
        rsa_result_i = '0;
        rd32(32'h04, d);
        check("reset_status", d, 32'h0);
        check("reset_irq", IRQ, 32'd0);
        rd32(32'h10, d);
        check("reset_data", d, 32'h0);
        exp_x = '0;
        check_x("x_after_reset");
        wr32(32'h00, 32'h2);
        rd32(32'h04, d);
        check("no_late_capture", d, 32'h0);
        check("no_late_irq", IRQ, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_rsa2048_ahb_slave
`default_nettype wire
